tbus_rx_ctrl: RTL and testbench

- Receiving end of a shared tristate bus built from inverting tristate drivers (A, EN -> Y = ~A when EN, else Z).
- N senders each own one such driver per bit; this block arbitrates ownership with one-hot EN outputs and inserts a turnaround cycle between owners.
- It samples the bus, re-inverts the data, buffers it in a small FIFO and presents it on a valid/ready output.
- Sits between the shared bus and a downstream consumer.

---
 rtl/tbus_pkg.sv | 26 ++
 rtl/tbus_rx_fifo.sv | 72 +++++++
 rtl/tbus_rx_ctrl.sv | 148 ++++++++++++++
 tb/tb_tbus_rx_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbus_pkg.sv
// -----------------------------------------------------------------------------
// tbus_pkg
// Shared types and helpers for the tristate-bus receive controller.
//   tbus_state_e  : arbitration state (IDLE, XFER, TURN)
//   count_width() : width of an occupancy counter spanning 0..depth
//   odd_parity_ok(): 1 when data plus parity bit carry odd parity
// -----------------------------------------------------------------------------
package tbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } tbus_state_e;

    // Occupancy must represent the full value depth, hence the extra bit.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Data is zero-extended by the caller; zero bits do not change the XOR.
    function automatic logic odd_parity_ok(input logic [63:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/tbus_rx_fifo.sv
// -----------------------------------------------------------------------------
// tbus_rx_fifo
// Synchronous DEPTH x W FIFO holding words captured from the bus.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset (flushes FIFO)
//   i_push, i_data   : write one word at the clock edge
//   i_pop            : consumer ready; a pop happens only while o_valid
//   o_data, o_valid  : head word and non-empty flag
//   o_count          : registered occupancy 0..DEPTH
//   o_next_count_c   : occupancy after this edge's push/pop (combinational)
// -----------------------------------------------------------------------------
module tbus_rx_fifo
    import tbus_pkg::*;
#(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = count_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_next_count_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          w_pop;

    assign w_pop          = i_pop & r_valid;
    assign o_next_count_c = r_count + CW'(i_push) - CW'(w_pop);

    // Storage array; a word presented during reset is not written.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= o_next_count_c;
            r_valid <= (o_next_count_c != '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/tbus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tbus_rx_ctrl
// Receiving end of a shared bus of inverting tristate drivers. Grants one
// sender at a time (round-robin, one-hot EN), inserts a one-cycle turnaround
// between owners, re-inverts the sampled bus and queues it for a consumer.
// Optional feature macro: TBUS_PARITY_EN (adds BUS_PAR input and sticky PERR).
// Ports:
//   CLK, RN            : clock, synchronous active-low reset
//   REQ[N]             : per-sender request level
//   EN[N]              : registered one-hot driver enable
//   BUS[W]             : resolved bus (inverted sender data)
//   OUT_DATA/VALID/READY: FIFO head with valid/ready handshake
//   COUNT              : FIFO occupancy 0..DEPTH
//   BUS_PAR, PERR      : inverted odd-parity line, sticky parity error
// -----------------------------------------------------------------------------
module tbus_rx_ctrl
    import tbus_pkg::*;
#(
    parameter  int unsigned N         = 4,
    parameter  int unsigned W         = 8,
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned CW        = count_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  EN,
    input  logic [W-1:0]  BUS,
    output logic [W-1:0]  OUT_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [CW-1:0] COUNT
`ifdef TBUS_PARITY_EN
    ,
    input  logic          BUS_PAR,
    output logic          PERR
`endif
);

    localparam int unsigned GW = $clog2(N);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    tbus_state_e   r_state;
    logic [N-1:0]  r_en;
    logic [GW-1:0] r_owner;
    logic [GW-1:0] r_rr;
    logic [BW-1:0] r_burst;

    logic          w_push;
    logic [W-1:0]  w_data;
    logic [CW-1:0] w_next_count;
    logic          w_room;
    logic          w_found;
    logic [GW-1:0] w_win;
    logic [GW-1:0] w_next_rr;

    // A word is on the bus for the whole XFER cycle and is taken at its end.
    assign w_push    = (r_state == XFER);
    assign w_data    = ~BUS;
    assign w_room    = (w_next_count < CW'(DEPTH));
    assign w_next_rr = (w_win == GW'(N - 1)) ? '0 : w_win + GW'(1);

    // Round-robin search starting at the slot after the last owner.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(r_rr) + i) % N;
            if (!w_found && REQ[GW'(idx)]) begin
                w_found = 1'b1;
                w_win   = GW'(idx);
            end
        end
    end

`ifdef TBUS_PARITY_EN
    logic w_par_ok;
    logic r_perr;

    assign w_par_ok = odd_parity_ok(64'(w_data), ~BUS_PAR);
    assign PERR     = r_perr;

    // Sticky until reset; the word itself is still queued.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_perr <= 1'b0;
        end else if (w_push && !w_par_ok) begin
            r_perr <= 1'b1;
        end
    end
`endif

    // Ownership state machine; EN is purely registered state.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= IDLE;
            r_en    <= '0;
            r_owner <= '0;
            r_rr    <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                XFER: begin
                    if (REQ[r_owner] && (r_burst < BW'(MAX_BURST)) && w_room) begin
                        r_burst <= r_burst + BW'(1);
                    end else begin
                        r_state <= TURN;
                        r_en    <= '0;
                    end
                end
                default: begin
                    // IDLE and TURN arbitrate identically.
                    if (w_found && w_room) begin
                        r_state <= XFER;
                        r_en    <= N'(1) << w_win;
                        r_owner <= w_win;
                        r_rr    <= w_next_rr;
                        r_burst <= BW'(1);
                    end else begin
                        r_state <= IDLE;
                        r_en    <= '0;
                    end
                end
            endcase
        end
    end

    assign EN = r_en;

    tbus_rx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk          (CLK),
        .i_rst_n        (RN),
        .i_push         (w_push),
        .i_data         (w_data),
        .i_pop          (OUT_READY),
        .o_data         (OUT_DATA),
        .o_valid        (OUT_VALID),
        .o_count        (COUNT),
        .o_next_count_c (w_next_count)
    );

endmodule

// File: tb/tb_tbus_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tbus_rx_ctrl
// Bench for tbus_rx_ctrl: models the senders' inverting drivers on the bus,
// keeps a queue of words expected at the output, and runs one task per
// scenario. Parity scenario is built only with TBUS_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_tbus_rx_ctrl;

    localparam int unsigned N         = 4;
    localparam int unsigned W         = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CW        = 3;

    logic          CLK = 1'b0;
    logic          RN  = 1'b0;
    logic [N-1:0]  REQ = '0;
    logic [N-1:0]  EN;
    logic [W-1:0]  BUS;
    logic [W-1:0]  OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [CW-1:0] COUNT;
`ifdef TBUS_PARITY_EN
    logic          BUS_PAR;
    logic          PERR;
    logic          bad_par = 1'b0;
`endif

    int checks  = 0;
    int errors  = 0;
    int n_deliv = 0;
    int n_cap   = 0;

    logic [W-1:0] data_mem [N][64];
    logic [5:0]   idx [N];
    logic [W-1:0] exp_q [$];

    always #5 CLK = ~CLK;

    tbus_rx_ctrl #(
        .N         (N),
        .W         (W),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK       (CLK),
        .RN        (RN),
        .REQ       (REQ),
        .EN        (EN),
        .BUS       (BUS),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT)
`ifdef TBUS_PARITY_EN
        ,
        .BUS_PAR   (BUS_PAR),
        .PERR      (PERR)
`endif
    );

    // Enabled sender drives the inverse of its current word; idle bus floats high.
    always_comb begin
        BUS = '1;
        for (int k = 0; k < N; k++) begin
            if (EN[k] == 1'b1) begin
                BUS = ~data_mem[k][idx[k]];
            end
        end
    end

`ifdef TBUS_PARITY_EN
    // Inverted odd-parity bit, deliberately wrong while bad_par is set.
    always_comb begin
        BUS_PAR = bad_par ? ~(^(~BUS)) : ^(~BUS);
    end
`endif

    // Scoreboard push: a word enabled at an edge with RN high is captured.
    always @(posedge CLK) begin
        if (!RN) begin
            exp_q.delete();
            for (int k = 0; k < N; k++) idx[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (EN[k] == 1'b1) begin
                    exp_q.push_back(data_mem[k][idx[k]]);
                    idx[k] <= idx[k] + 6'd1;
                    n_cap++;
                end
            end
        end
    end

    // Scoreboard pop on handshake, plus one-hot EN check every cycle.
    always @(negedge CLK) begin
        logic [W-1:0] e;
        if (RN === 1'b1) begin
            checks++;
            if ($countones(EN) > 1) begin
                errors++;
                $display("FAIL en_onehot got %b", EN);
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                checks++;
                n_deliv++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard unexpected word got %h", OUT_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (OUT_DATA !== e) begin
                        errors++;
                        $display("FAIL scoreboard data got %h exp %h", OUT_DATA, e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        REQ       = '0;
        OUT_READY = 1'b1;
`ifdef TBUS_PARITY_EN
        bad_par   = 1'b0;
`endif
        RN = 1'b0;
        cyc();
        cyc();
        RN = 1'b1;
    endtask

    task automatic drain();
        int t;
        t         = 0;
        REQ       = '0;
        OUT_READY = 1'b1;
        while ((exp_q.size() != 0 || EN != '0 || OUT_VALID) && t < 200) begin
            cyc();
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL drain_timeout got %0d words pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        REQ       = 4'b1111;
        OUT_READY = 1'b1;
        RN        = 1'b0;
        cyc();
        cyc();
        checks += 3;
        if (EN !== 4'b0000) begin errors++; $display("FAIL reset_en got %b exp 0000", EN); end
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", OUT_VALID); end
        if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
        RN = 1'b1;
        cyc();
        checks++;
        if (EN !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", EN); end
        drain();
    endtask

    task automatic test_single_burst();
        logic [W-1:0] vals [4];
        int d0;
        vals = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        do_reset();
        for (int j = 0; j < 4; j++) data_mem[2][j] = vals[j];
        d0  = n_deliv;
        REQ = 4'b0100;
        cyc();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (EN !== 4'b0100) begin errors++; $display("FAIL burst_en[%0d] got %b exp 0100", i, EN); end
            if (i == 0) begin
                checks++;
                if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL burst_early_valid got %b exp 0", OUT_VALID); end
            end
            if (i == 1) begin
                checks++;
                if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA5) begin
                    errors++;
                    $display("FAIL burst_latency got v=%b d=%h exp v=1 d=a5", OUT_VALID, OUT_DATA);
                end
            end
            cyc();
        end
        checks++;
        if (EN !== 4'b0000) begin errors++; $display("FAIL burst_turn got %b exp 0000", EN); end
        REQ = '0;
        drain();
        checks++;
        if (n_deliv - d0 != 4) begin errors++; $display("FAIL burst_count got %0d exp 4", n_deliv - d0); end
    endtask

    task automatic test_round_robin();
        int g [4];
        g = '{0, 1, 3, 0};
        do_reset();
        REQ = 4'b1011;
        cyc();
        for (int gi = 0; gi < 4; gi++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (EN !== 4'(1 << g[gi])) begin
                    errors++;
                    $display("FAIL rr_grant[%0d.%0d] got %b exp %b", gi, c, EN, 4'(1 << g[gi]));
                end
                cyc();
            end
            if (gi < 3) begin
                checks++;
                if (EN !== 4'b0000) begin errors++; $display("FAIL rr_turn[%0d] got %b exp 0000", gi, EN); end
                cyc();
            end
        end
        REQ = '0;
        drain();
`ifdef TBUS_PARITY_EN
        checks++;
        if (PERR !== 1'b0) begin errors++; $display("FAIL rr_perr got %b exp 0", PERR); end
`endif
    endtask

    task automatic test_backpressure();
        int n_en;
        int g2;
        int d0;
        int c0;
        do_reset();
        n_en      = 0;
        g2        = 0;
        d0        = n_deliv;
        c0        = n_cap;
        OUT_READY = 1'b0;
        REQ       = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (EN == 4'b0010) n_en++;
        end
        checks += 4;
        if (n_en != 4) begin errors++; $display("FAIL bp_words got %0d exp 4", n_en); end
        if (COUNT !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", COUNT); end
        if (EN !== 4'b0000) begin errors++; $display("FAIL bp_en got %b exp 0000", EN); end
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", OUT_VALID); end
        OUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (EN == 4'b0010) g2++;
        end
        checks++;
        if (g2 == 0) begin errors++; $display("FAIL bp_resume got %0d grants exp >0", g2); end
        drain();
        checks++;
        if ((n_deliv - d0) != (n_cap - c0)) begin
            errors++;
            $display("FAIL bp_lossless got %0d delivered exp %0d", n_deliv - d0, n_cap - c0);
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        do_reset();
        OUT_READY = 1'b1;
        REQ       = 4'b0001;
        cyc();
        checks++;
        if (EN !== 4'b0001) begin errors++; $display("FAIL mid_first_xfer got %b exp 0001", EN); end
        cyc();
        checks++;
        if (EN !== 4'b0001) begin errors++; $display("FAIL mid_second_xfer got %b exp 0001", EN); end
        d0  = n_deliv;
        RN  = 1'b0;
        REQ = '0;
        cyc();
        checks += 3;
        if (EN !== 4'b0000) begin errors++; $display("FAIL mid_en got %b exp 0000", EN); end
        if (COUNT !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", COUNT); end
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", OUT_VALID); end
        RN = 1'b1;
        repeat (6) cyc();
        checks++;
        if (n_deliv != d0) begin errors++; $display("FAIL mid_absent got %0d words exp 0", n_deliv - d0); end
    endtask

`ifdef TBUS_PARITY_EN
    task automatic test_parity();
        int d0;
        do_reset();
        checks++;
        if (PERR !== 1'b0) begin errors++; $display("FAIL par_reset got %b exp 0", PERR); end
        data_mem[3][0] = 8'h01;
        d0      = n_deliv;
        bad_par = 1'b1;
        REQ     = 4'b1000;
        cyc();
        REQ = '0;
        checks++;
        if (EN !== 4'b1000) begin errors++; $display("FAIL par_grant got %b exp 1000", EN); end
        cyc();
        bad_par = 1'b0;
        checks += 2;
        if (PERR !== 1'b1) begin errors++; $display("FAIL par_set got %b exp 1", PERR); end
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h01) begin
            errors++;
            $display("FAIL par_word got v=%b d=%h exp v=1 d=01", OUT_VALID, OUT_DATA);
        end
        repeat (5) cyc();
        checks += 2;
        if (PERR !== 1'b1) begin errors++; $display("FAIL par_sticky got %b exp 1", PERR); end
        if (n_deliv - d0 != 1) begin errors++; $display("FAIL par_delivered got %0d exp 1", n_deliv - d0); end
    endtask
`endif

    initial begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 64; j++) begin
                data_mem[k][j] = 8'($urandom);
            end
        end
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
`ifdef TBUS_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
